// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- PC owner and instruction fetch front end of the single-cycle MIPS core.
//
// Fetches one instruction word per instruction over a req/ready handshake and
// holds it for the control unit. The control unit's JUMP/BRANCH/JR decisions
// then select the next PC, which is loaded when the instruction commits.
//
// Optional feature: define MISALIGN_TRAP_EN to trap on a misaligned next PC.
// Without it, next_pc[1:0] are cleared before the PC is loaded, and trap is tied low.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   imem_req/imem_addr   fetch request and byte address (= pc)
//   imem_rdata/ready     instruction word and its valid strobe
//   jump/branch/jr       control unit PC-select (branch already qualified by Z)
//   rs_data              register rs value, the jr target
//   commit               held instruction finished executing this cycle
//   instr + slices       held instruction word, with op/func/rs/rt/rd/imm16 fields
//   instr_valid          instr holds a fetched, uncommitted instruction
//   pc, pc_plus4         address of the held instruction, and the link value
//   trap                 misaligned-target trap
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        jr,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_TRAP} state_t;

  state_t      state, state_nxt;
  logic        load_instr, load_pc;
  logic [31:0] br_off, next_pc, pc_load;

  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign imm16     = instr[15:0];
  assign func      = instr[5:0];
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};

  // Priority: jr over jump (the control unit raises jump with jr), jump over branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)          next_pc = rs_data;
    else if (jump)   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch) next_pc = pc_plus4 + br_off;
  end

`ifdef MISALIGN_TRAP_EN
  assign pc_load = next_pc;
  assign trap    = (state == S_TRAP);
`else
  assign pc_load = next_pc & 32'hFFFF_FFFC;
  assign trap    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit) begin
          load_pc   = 1'b1;
          state_nxt = S_FETCH;
`ifdef MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) state_nxt = S_TRAP;
`endif
        end
      end
      default: ; // S_TRAP: held until reset
    endcase
    // A request must never be visible while reset is applied.
    if (rst) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (load_pc) begin
        pc          <= pc_load;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, imem_ready, jump, branch, jr, commit;
  logic [31:0] imem_rdata, rs_data;
  logic        imem_req, instr_valid, trap;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the fetch unit is holding, in plain terms.
  logic [31:0] m_pc, m_instr;
  bit          m_have;   // holding a fetched, uncommitted instruction
  bit          m_trap;   // stopped on a misaligned target

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .jump(jump),
    .branch(branch), .jr(jr), .rs_data(rs_data), .commit(commit),
    .instr(instr), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .trap(trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] w);
    logic [31:0] p4;
    int          off;
    p4  = cur + 32'd4;
    off = $signed(w[15:0]);
    if (jr)          return rs_data;
    else if (jump)   return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    else if (branch) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic model_step();
    logic [31:0] t;
    if (rst) begin
      m_pc = 32'h0000_3000; m_instr = '0; m_have = 0; m_trap = 0;
    end else if (m_trap) begin
    end else if (!m_have) begin
      if (imem_ready) begin m_instr = imem_rdata; m_have = 1; end
    end else if (commit) begin
      t = target(m_pc, m_instr);
      m_have = 0;
`ifdef MISALIGN_TRAP_EN
      m_pc = t;
      if (t[1:0] != 2'b00) m_trap = 1;
`else
      m_pc = {t[31:2], 2'b00};
`endif
    end
  endtask

  task automatic check_all();
    bit exp_req;
    exp_req = !rst && !m_have && !m_trap;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr_valid", instr_valid, m_have);
    chk("instr", instr, m_instr);
    chk("op", op, m_instr[31:26]);
    chk("func", func, m_instr[5:0]);
    chk("rs", rs, m_instr[25:21]);
    chk("rt", rt, m_instr[20:16]);
    chk("rd", rd, m_instr[15:11]);
    chk("imm16", imm16, m_instr[15:0]);
    chk("trap", trap, m_trap);
  endtask

  // One clock: check mid-cycle, advance model with the inputs seen at the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_instr(input logic [31:0] w, input int wait_cyc, input bit c_jr,
                           input bit c_jump, input bit c_br, input logic [31:0] rsd);
    commit = 0; jr = 0; jump = 0; branch = 0;
    imem_ready = 0;
    repeat (wait_cyc) begin imem_rdata = $urandom; cycle(); end
    imem_ready = 1; imem_rdata = w; cycle();
    imem_ready = $urandom_range(0, 1); imem_rdata = $urandom;
    jr = c_jr; jump = c_jump; branch = c_br; rs_data = rsd; commit = 1;
    cycle();
    commit = 0; jr = 0; jump = 0; branch = 0; imem_ready = 0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    run_instr($urandom, 0, 1, 1, 0, a);
  endtask

  initial begin
    rst = 1; imem_ready = 0; jump = 0; branch = 0; jr = 0; commit = 0;
    imem_rdata = '0; rs_data = '0;
    @(posedge clk); model_step(); #1;
    cycle();                              // reset held: no request
    rst = 0;

    // 1: fetch at reset PC with ready every cycle, then sequential advance
    imem_ready = 1; imem_rdata = 32'h2008_0001;
    cycle();
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_instr", instr, 32'h2008_0001);
    commit = 1; imem_ready = 0; cycle(); commit = 0;
    chk("t1_next", pc, 32'h0000_3004);

    // 2: ready delayed 3 cycles
    run_instr(32'h0123_4567, 3, 0, 0, 0, 0);
    chk("t2_next", pc, 32'h0000_3008);

    // 3: backward branch, then not taken
    goto_pc(32'h0000_3010);
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFC}, 0, 0, 0, 1, 0);
    chk("t3_taken", pc, 32'h0000_3004);
    goto_pc(32'h0000_3010);
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFC}, 1, 0, 0, 0, 0);
    chk("t3_fall", pc, 32'h0000_3014);

    // 4: j and jr+jump priority
    goto_pc(32'h0000_3020);
    run_instr({6'h02, 26'h000_0C10}, 0, 0, 1, 1, 0);
    chk("t4_j", pc, 32'h0000_3040);
    run_instr({6'h02, 26'h000_0C10}, 2, 1, 1, 1, 32'h0000_3100);
    chk("t4_jr", pc, 32'h0000_3100);

    // 5: PC wrap, then reset during execute
    goto_pc(32'hFFFF_FFFC);
    chk("t5_p4", pc_plus4, 32'h0000_0000);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0);
    chk("t5_wrap", pc, 32'h0000_0000);
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; cycle();
    imem_ready = 0; commit = 0; rst = 1; cycle(); rst = 0;
    chk("t5_rst_pc", pc, 32'h0000_3000);
    chk("t5_rst_valid", instr_valid, 1'b0);

    // 6: misaligned jr target
    goto_pc(32'h0000_3102);
`ifdef MISALIGN_TRAP_EN
    chk("t6_trap", trap, 1'b1);
    chk("t6_pc", pc, 32'h0000_3102);
    chk("t6_req", imem_req, 1'b0);
    imem_ready = 1; commit = 1; cycle(); cycle();
    chk("t6_stuck", trap, 1'b1);
    commit = 0; rst = 1; cycle(); rst = 0;
`else
    chk("t6_pc", pc, 32'h0000_3100);
    chk("t6_trap", trap, 1'b0);
`endif

    // Random traffic: stray ready/commit, mixed controls, occasional reset
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      imem_ready = $urandom_range(0, 1);
      imem_rdata = $urandom;
      commit     = $urandom_range(0, 1);
      jr         = ($urandom_range(0, 5) == 0);
      jump       = jr | ($urandom_range(0, 4) == 0);
      branch     = $urandom_range(0, 1);
      rs_data    = $urandom;
      if ($urandom_range(0, 3) != 0) rs_data[1:0] = 2'b00;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
